// File: rtl/countdown_sequencer.sv
// Two-digit BCD countdown controller: divides clock into ticks, applies the
// units-to-tens borrow, and sequences load/start/pause/clear with a done flag.
//
// state | meaning
// IDLE  | stopped, value loadable, prescaler at 0
// RUN   | prescaler counting, one BCD step per tick
// PAUSE | digits and prescaler frozen, value loadable
// DONE  | reached 00, holding until load or clear
module countdown_sequencer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic       running,
  output logic       zero,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state_q, state_nxt;
  logic [3:0]       tens_q, units_q, tens_nxt, units_nxt;
  logic [3:0]       tens_dec, units_dec;
  logic [CNT_W-1:0] presc_q, presc_nxt;
  logic             done_q;
  logic             tick, val_zero, dec_zero;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign val_zero = (tens_q == 4'd0) && (units_q == 4'd0);
  assign tick     = (presc_q == PRESC_LAST);
  assign dec_zero = (tens_dec == 4'd0) && (units_dec == 4'd0);

  // One BCD step down; saturates at 00 so the value can never wrap to 99.
  always_comb begin
    tens_dec  = tens_q;
    units_dec = units_q - 4'd1;
    if (val_zero) begin
      tens_dec  = 4'd0;
      units_dec = 4'd0;
    end else if (units_q == 4'd0) begin
      units_dec = 4'd9;
      tens_dec  = tens_q - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      tens_q  <= tens_nxt;
      units_q <= units_nxt;
      presc_q <= presc_nxt;
      done_q  <= (state_nxt == S_DONE) && (state_q != S_DONE);
    end
  end

  always_comb begin
    state_nxt = state_q;
    tens_nxt  = tens_q;
    units_nxt = units_q;
    presc_nxt = presc_q;
    if (clear) begin
      state_nxt = S_IDLE;
      tens_nxt  = 4'd0;
      units_nxt = 4'd0;
      presc_nxt = '0;
    end else if (load && (state_q != S_RUN)) begin
      tens_nxt  = clamp9(load_tens);
      units_nxt = clamp9(load_units);
      presc_nxt = '0;
      if (state_q == S_DONE) state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !val_zero) begin
            state_nxt = S_RUN;
            presc_nxt = '0;
          end
        end
        S_RUN: begin
          // A tick coinciding with pause is applied first; reaching 00 beats pause.
          if (tick) begin
            presc_nxt = '0;
            tens_nxt  = tens_dec;
            units_nxt = units_dec;
            if (dec_zero)   state_nxt = S_DONE;
            else if (pause) state_nxt = S_PAUSE;
          end else if (pause) begin
            state_nxt = S_PAUSE;
          end else begin
            presc_nxt = presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (start && !val_zero) state_nxt = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bcd_tens  = tens_q;
    bcd_units = units_q;
    running   = (state_q == S_RUN);
    zero      = val_zero;
    done      = done_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: vector table, hand-written corner sequences,
// and random stimulus checked against an integer-valued reference model.
module tb_countdown_sequencer;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clock = 1'b0;
  logic       reset, clear, load, start, pause;
  logic [3:0] load_tens, load_units, bcd_tens, bcd_units;
  logic       running, zero, done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  int m_val, m_mode, m_cnt;
  int m_done;

  typedef struct {
    bit c, l;
    logic [3:0] lt, lu;
    bit s, p;
    int et, eu, es, ed;
  } vec_t;
  vec_t vt[$];

  always #5 clock = ~clock;

  countdown_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .load(load),
    .load_tens(load_tens), .load_units(load_units), .start(start), .pause(pause),
    .bcd_tens(bcd_tens), .bcd_units(bcd_units), .running(running), .zero(zero),
    .done(done), .state(state)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_mode = M_IDLE; m_cnt = 0; m_done = 0;
  endtask

  // Value kept as a plain integer 0..99; a tick subtracts one.
  task automatic model_step(input bit c, l, input int lt, lu, input bit s, p);
    m_done = 0;
    if (c) begin
      m_val = 0; m_mode = M_IDLE; m_cnt = 0;
    end else if (l && m_mode != M_RUN) begin
      m_val = ((lt > 9) ? 9 : lt) * 10 + ((lu > 9) ? 9 : lu);
      m_cnt = 0;
      if (m_mode == M_DONE) m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (s && m_val != 0) begin m_mode = M_RUN; m_cnt = 0; end
        M_RUN: begin
          if (m_cnt == TICK_DIV - 1) begin
            m_cnt = 0;
            m_val = m_val - 1;
            if (m_val == 0) begin m_mode = M_DONE; m_done = 1; end
            else if (p) m_mode = M_PAUSE;
          end else if (p) m_mode = M_PAUSE;
          else m_cnt = m_cnt + 1;
        end
        M_PAUSE: if (s && m_val != 0) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic check_model();
    chk("model tens", int'(bcd_tens), m_val / 10);
    chk("model units", int'(bcd_units), m_val % 10);
    chk("model state", int'(state), m_mode);
    chk("model running", int'(running), (m_mode == M_RUN) ? 1 : 0);
    chk("model zero", int'(zero), (m_val == 0) ? 1 : 0);
    chk("model done", int'(done), m_done);
  endtask

  task automatic step(input bit c, l, input logic [3:0] lt, lu, input bit s, p);
    @(negedge clock);
    clear = c; load = l; load_tens = lt; load_units = lu; start = s; pause = p;
    @(posedge clock);
    model_step(c, l, int'(lt), int'(lu), s, p);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 4'd0, 0, 0);
  endtask

  function automatic int value();
    return int'(bcd_tens) * 10 + int'(bcd_units);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, cur, n, pulses;
    reset = 1'b1; clear = 0; load = 0; start = 0; pause = 0;
    load_tens = 4'd0; load_units = 4'd0;
    model_reset();
    #12;
    chk("reset tens", int'(bcd_tens), 0);
    chk("reset units", int'(bcd_units), 0);
    chk("reset state", int'(state), M_IDLE);
    chk("reset zero", int'(zero), 1);
    chk("reset done", int'(done), 0);
    chk("reset running", int'(running), 0);
    @(negedge clock) reset = 1'b0;

    // 1: idle after reset
    idle(10);
    chk("idle zero", int'(zero), 1);
    chk("idle state", int'(state), M_IDLE);

    // table vectors: {clear, load, lt, lu, start, pause, tens, units, state, done}
    vt.push_back('{0, 1, 4'hA, 4'hF, 0, 0, 9, 9, 0, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 9, 9, 0, 0});
    vt.push_back('{0, 1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 4'h0, 4'h2, 0, 0, 0, 2, 0, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 1, 0, 0, 2, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 2, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 2, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 2, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0});
    vt.push_back('{0, 1, 4'h5, 4'h5, 0, 0, 0, 1, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 1, 0, 1, 2, 0});
    vt.push_back('{0, 1, 4'h0, 4'h3, 0, 0, 0, 3, 2, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 1, 0, 0, 3, 1, 0});
    vt.push_back('{1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{0, 1, 4'h0, 4'h1, 0, 0, 0, 1, 0, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 3, 1});
    vt.push_back('{0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 3, 0});
    vt.push_back('{0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 3, 0});
    vt.push_back('{0, 1, 4'h1, 4'h0, 0, 0, 1, 0, 0, 0});
    vt.push_back('{1, 1, 4'h7, 4'h7, 1, 0, 0, 0, 0, 0});
    foreach (vt[i]) begin
      step(vt[i].c, vt[i].l, vt[i].lt, vt[i].lu, vt[i].s, vt[i].p);
      chk($sformatf("vec%0d tens", i), int'(bcd_tens), vt[i].et);
      chk($sformatf("vec%0d units", i), int'(bcd_units), vt[i].eu);
      chk($sformatf("vec%0d state", i), int'(state), vt[i].es);
      chk($sformatf("vec%0d done", i), int'(done), vt[i].ed);
    end

    // 2: full countdown from 12 with borrow and a single done pulse
    step(1, 0, 4'd0, 4'd0, 0, 0);
    step(0, 1, 4'd1, 4'd2, 0, 0);
    step(0, 0, 4'd0, 4'd0, 1, 0);
    prev = 12; n = 0; pulses = 0;
    while (state != 2'b11 && n < 200) begin
      idle(1);
      n++;
      if (done) pulses++;
      cur = value();
      if (cur != prev) begin
        chk("countdown step", cur, prev - 1);
        if (prev == 10) begin
          chk("borrow tens", int'(bcd_tens), 0);
          chk("borrow units", int'(bcd_units), 9);
        end
        prev = cur;
      end
    end
    chk("cycles to done", n, 12 * TICK_DIV);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (done) pulses++;
    end
    chk("done pulses", pulses, 1);
    chk("done state", int'(state), M_DONE);
    chk("done value", value(), 0);

    // 3: pause with held prescaler, resume timing
    step(1, 0, 4'd0, 4'd0, 0, 0);
    step(0, 1, 4'd0, 4'd5, 0, 0);
    step(0, 0, 4'd0, 4'd0, 1, 0);
    idle(6);
    step(0, 0, 4'd0, 4'd0, 0, 1);
    chk("paused state", int'(state), M_PAUSE);
    chk("paused value", value(), 4);
    idle(20);
    chk("held value", value(), 4);
    chk("held state", int'(state), M_PAUSE);
    step(0, 0, 4'd0, 4'd0, 1, 0);
    chk("resumed state", int'(state), M_RUN);
    n = 0;
    while (value() != 3 && n < 20) begin
      idle(1);
      n++;
    end
    chk("resume latency", n, 2);

    // 4: invalid digits clamp, start on 00 ignored
    step(1, 0, 4'd0, 4'd0, 0, 0);
    step(0, 1, 4'hA, 4'hF, 0, 0);
    chk("clamp value", value(), 99);
    step(0, 1, 4'd0, 4'd0, 0, 0);
    step(0, 0, 4'd0, 4'd0, 1, 0);
    chk("start 00 state", int'(state), M_IDLE);
    idle(3);
    chk("start 00 done", int'(done), 0);

    // 5: pause on the final tick -> DONE wins
    step(0, 1, 4'd0, 4'd1, 0, 0);
    step(0, 0, 4'd0, 4'd0, 1, 0);
    idle(TICK_DIV - 1);
    step(0, 0, 4'd0, 4'd0, 0, 1);
    chk("pause tick state", int'(state), M_DONE);
    chk("pause tick done", int'(done), 1);
    chk("pause tick value", value(), 0);

    // 6: async reset mid-run, clear in RUN, load ignored in RUN
    step(0, 1, 4'd3, 4'd0, 0, 0);
    step(0, 0, 4'd0, 4'd0, 1, 0);
    idle(5);
    #2 reset = 1'b1;
    #1;
    chk("async reset value", value(), 0);
    chk("async reset state", int'(state), M_IDLE);
    chk("async reset running", int'(running), 0);
    chk("async reset zero", int'(zero), 1);
    model_reset();
    @(negedge clock) reset = 1'b0;
    idle(3);
    step(0, 1, 4'd3, 4'd0, 0, 0);
    step(0, 0, 4'd0, 4'd0, 1, 0);
    idle(2);
    step(1, 0, 4'd0, 4'd0, 0, 0);
    chk("clear in run value", value(), 0);
    chk("clear in run state", int'(state), M_IDLE);
    step(0, 1, 4'd3, 4'd0, 0, 0);
    step(0, 0, 4'd0, 4'd0, 1, 0);
    idle(1);
    step(0, 1, 4'd9, 4'd9, 0, 0);
    chk("load in run value", value(), 30);
    chk("load in run state", int'(state), M_RUN);

    // random stimulus against the model
    step(1, 0, 4'd0, 4'd0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit c, l, s, p;
      logic [3:0] lt, lu;
      c  = ($urandom_range(0, 99) < 1);
      l  = ($urandom_range(0, 99) < 8);
      s  = ($urandom_range(0, 99) < 20);
      p  = ($urandom_range(0, 99) < 5);
      lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      lu = 4'($urandom_range(0, 15));
      step(c, l, lt, lu, s, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
